// File: rtl/write_buffer_if.sv
// CPU store/load port and main-memory write port of the posted-write buffer.
// The buffer connects through the slave modport; the CPU/memory side uses master.
interface write_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  MemWrite;
    logic                  MemRead;
    logic [ADDR_WIDTH-1:0] WordAddress;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  Stall;
    logic                  Empty;
    logic                  Fwd_Hit;
    logic [DATA_WIDTH-1:0] Fwd_Data;
    logic                  Main_Wr;
    logic [ADDR_WIDTH-1:0] Main_Addr;
    logic [DATA_WIDTH-1:0] Main_Data;
    logic                  Main_Ack;

    modport master (
        output MemWrite, MemRead, WordAddress, DataIn, Main_Ack,
        input  Stall, Empty, Fwd_Hit, Fwd_Data, Main_Wr, Main_Addr, Main_Data
    );

    modport slave (
        input  MemWrite, MemRead, WordAddress, DataIn, Main_Ack,
        output Stall, Empty, Fwd_Hit, Fwd_Data, Main_Wr, Main_Addr, Main_Data
    );
endinterface

// File: rtl/write_buffer.sv
// Posted-write FIFO: accepts CPU stores in one cycle, drains them to main
// memory over a req/ack handshake and forwards buffered data to loads.
module write_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic           CLK,
    input  logic           rst_n,
    write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    state_t                r_state;
    state_t                w_next_state;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_main_wr;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_match_data;
    logic [PTR_W-1:0]      w_idx;

    assign w_full = (r_count == FULL_CNT);
    assign w_push = bus.MemWrite & ~w_full;
    assign w_pop  = (r_state == BUSY) & bus.Main_Ack;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            // A push never targets the head being popped: that needs full or empty.
            if (w_push) begin
                r_addr[r_wr_ptr]  <= bus.WordAddress;
                r_data[r_wr_ptr]  <= bus.DataIn;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_main_wr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) w_next_state = BUSY;
            end
            BUSY: begin
                w_main_wr = 1'b1;
                if (bus.Main_Ack) w_next_state = GAP;
            end
            GAP: begin
                w_next_state = (r_count != '0) ? BUSY : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Walk entries oldest to newest so the newest match overwrites older ones.
    always_comb begin
        w_match      = 1'b0;
        w_match_data = '0;
        w_idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == bus.WordAddress)) begin
                w_match      = 1'b1;
                w_match_data = r_data[w_idx];
            end
        end
    end

    assign bus.Stall     = bus.MemWrite & w_full;
    assign bus.Empty     = (r_count == '0);
    assign bus.Fwd_Hit   = bus.MemRead & w_match;
    assign bus.Fwd_Data  = (bus.MemRead & w_match) ? w_match_data : '0;
    assign bus.Main_Wr   = w_main_wr;
    assign bus.Main_Addr = r_addr[r_rd_ptr];
    assign bus.Main_Data = r_data[r_rd_ptr];
endmodule

// File: tb/tb_write_buffer.sv
// Directed and random checks of write_buffer against a queue-based model of
// the posted-write buffer.
module tb_write_buffer;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    entry_t q[$];
    bit     m_wr;
    bit     m_gap;

    write_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr  = 1'b0;
        m_gap = 1'b0;
    endtask

    // Expected combinational outputs for the currently driven inputs.
    task automatic check_outputs(input string phase);
        bit            hit;
        logic [DW-1:0] fd;
        hit = 1'b0;
        fd  = '0;
        if (bus.MemRead) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == bus.WordAddress) begin
                    hit = 1'b1;
                    fd  = q[i].d;
                    break;
                end
            end
        end
        check({phase, ".stall"}, 64'(bus.Stall), 64'(bus.MemWrite && q.size() == DEPTH));
        check({phase, ".empty"}, 64'(bus.Empty), 64'(q.size() == 0));
        check({phase, ".fwd_hit"}, 64'(bus.Fwd_Hit), 64'(hit));
        check({phase, ".fwd_data"}, 64'(bus.Fwd_Data), 64'(fd));
        check({phase, ".main_wr"}, 64'(bus.Main_Wr), 64'(m_wr));
        if (m_wr && q.size() != 0) begin
            check({phase, ".main_addr"}, 64'(bus.Main_Addr), 64'(q[0].a));
            check({phase, ".main_data"}, 64'(bus.Main_Data), 64'(q[0].d));
        end
    endtask

    // Drain request starts the cycle after the buffer is seen non-empty,
    // ends on an ack, and is followed by one forced quiet cycle.
    task automatic model_edge(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic ack);
        int pre;
        pre = q.size();
        if (m_wr) begin
            if (ack) begin
                void'(q.pop_front());
                m_wr  = 1'b0;
                m_gap = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_wr  = (pre != 0);
        end else begin
            m_wr = (pre != 0);
        end
        if (we && pre < DEPTH) q.push_back('{a: a, d: d});
    endtask

    task automatic step(input string phase, input logic we, input logic re,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack);
        bus.MemWrite    = we;
        bus.MemRead     = re;
        bus.WordAddress = a;
        bus.DataIn      = d;
        bus.Main_Ack    = ack;
        @(negedge CLK);
        check_outputs(phase);
        @(posedge CLK);
        model_edge(we, a, d, ack);
        #1;
    endtask

    initial begin
        bus.MemWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.WordAddress = '0;
        bus.DataIn      = '0;
        bus.Main_Ack    = 1'b0;
        model_reset();

        // Reset values
        #2;
        check("rst.empty", 64'(bus.Empty), 64'd1);
        check("rst.stall", 64'(bus.Stall), 64'd0);
        check("rst.main_wr", 64'(bus.Main_Wr), 64'd0);
        check("rst.main_addr", 64'(bus.Main_Addr), 64'd0);
        check("rst.main_data", 64'(bus.Main_Data), 64'd0);
        check("rst.fwd_data", 64'(bus.Fwd_Data), 64'd0);
        @(posedge CLK);
        #1 rst_n = 1'b1;

        // Single store, acked three cycles after the request rises
        step("t1", 1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
        step("t1", 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        check("t1.wr_one_after_push", 64'(bus.Main_Wr), 64'd1);
        step("t1", 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        step("t1", 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        step("t1", 1'b0, 1'b0, 10'h000, 32'h0, 1'b1);
        step("t1", 1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        check("t1.empty_after", 64'(bus.Empty), 64'd1);

        // Fill to full, stall a fifth store, then ack once and refill
        for (int i = 0; i < DEPTH; i++)
            step("t2", 1'b1, 1'b0, 10'(10'h100 + i), 32'(32'hA000 + i), 1'b0);
        step("t2.fifth", 1'b1, 1'b0, 10'h1FF, 32'hBAD, 1'b0);
        step("t2", 1'b0, 1'b0, 10'h000, 32'h0, 1'b1);
        step("t2.refill", 1'b1, 1'b0, 10'h104, 32'hA004, 1'b0);
        for (int i = 0; i < 12; i++)
            step("t2.drain", 1'b0, 1'b0, 10'h000, 32'h0, 1'(i % 2));

        // Forwarding: newest of two matching entries wins
        step("t3", 1'b1, 1'b0, 10'h020, 32'h1, 1'b0);
        step("t3", 1'b1, 1'b0, 10'h020, 32'h2, 1'b0);
        step("t3.hit", 1'b0, 1'b1, 10'h020, 32'h0, 1'b0);
        check("t3.fwd_newest", 64'(bus.Fwd_Data), 64'h2);
        step("t3.miss", 1'b0, 1'b1, 10'h021, 32'h0, 1'b0);
        step("t3.noread", 1'b0, 1'b0, 10'h020, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            step("t3.drain", 1'b0, 1'b1, 10'h020, 32'h0, 1'b1);

        // Continuous stores with ack tied high: pointers wrap several times
        for (int i = 0; i < 16; i++)
            step("t4", 1'b1, 1'b1, 10'(10'h200 + i), $urandom, 1'b1);
        for (int i = 0; i < 10; i++)
            step("t4.drain", 1'b0, 1'b0, 10'h000, 32'h0, 1'b1);

        // Reset while a transfer is in flight with three entries held
        for (int i = 0; i < 3; i++)
            step("t5", 1'b1, 1'b0, 10'(10'h300 + i), 32'(32'hC000 + i), 1'b0);
        check("t5.busy_before_rst", 64'(bus.Main_Wr), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5.wr_drop", 64'(bus.Main_Wr), 64'd0);
        check("t5.empty", 64'(bus.Empty), 64'd1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            step("t5.quiet", 1'b0, 1'b1, 10'h300, 32'h0, 1'b1);

        // Random traffic with a small address range to exercise forwarding
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 10'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
